// File: rtl/ps2_device_if_if.sv
// Byte-level handshake between the PS/2 device link controller (slave) and its user logic (master).
interface ps2_device_if_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_ferr;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_abort, rx_data, rx_valid, rx_perr, rx_ferr
    );
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_abort, rx_data, rx_valid, rx_perr, rx_ferr
    );
endinterface

// File: rtl/ps2_device_if.sv
// PS/2 device-side link controller: drives ps2_clk, sends 11-bit frames, receives host commands with ack.
// Define PS2_DEV_TXFIFO_EN for a 4-entry TX FIFO instead of the single pending-byte register.
//
//  state       | meaning
//  S_IDLE      | bus idle, lines released, watching for RTS or pending byte
//  S_TX_HI     | TX clk released, data bit set up after SetupTc
//  S_TX_LO     | TX clk pulled low
//  S_WAIT_REL  | host inhibit seen, waiting for clk release
//  S_RX_WAIT   | host RTS, start bit held by host
//  S_RX_LO     | RX clk pulled low
//  S_RX_HI     | RX clk released, dat sampled mid-phase
//  S_RX_ACK_LO | clock pulse 11 low (ack driven if stop was 1)
//  S_RX_ACK_HI | clock pulse 11 high, dat released
module ps2_device_if #(
    parameter real FCLK_HZ   = 50.0e6,
    parameter real T_HALF_S  = 40.0e-6,
    parameter real T_IDLE_S  = 50.0e-6,
    parameter real T_SETUP_S = 5.0e-6
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_device_if_if.slave bus,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_dat,
    output logic           o_ps2_clk_od,
    output logic           o_ps2_dat_od
);
    // The small bias keeps an exact product from rounding up a whole count.
    localparam int HALF_I  = $rtoi($ceil(FCLK_HZ * T_HALF_S  - 1.0e-6)) - 1;
    localparam int IDLE_I  = $rtoi($ceil(FCLK_HZ * T_IDLE_S  - 1.0e-6)) - 1;
    localparam int SETUP_I = $rtoi($ceil(FCLK_HZ * T_SETUP_S - 1.0e-6)) - 1;
    localparam int MAX_I   = (HALF_I > IDLE_I) ? HALF_I : IDLE_I;
    localparam int MID_I   = HALF_I / 2;
    localparam int TW      = $clog2(MAX_I + 2);

    localparam logic [TW-1:0] HALF_TC  = HALF_I[TW-1:0];
    localparam logic [TW-1:0] IDLE_TC  = IDLE_I[TW-1:0];
    localparam logic [TW-1:0] SETUP_TC = SETUP_I[TW-1:0];
    localparam logic [TW-1:0] MID_TC   = MID_I[TW-1:0];

    typedef enum logic [3:0] {
        S_IDLE, S_TX_HI, S_TX_LO, S_WAIT_REL, S_RX_WAIT,
        S_RX_LO, S_RX_HI, S_RX_ACK_LO, S_RX_ACK_HI
    } state_t;

    state_t        r_state, w_nxt;
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [TW-1:0] r_tmr;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_stop;
    logic          r_clk_od, r_dat_od;
    logic          r_tx_done, r_tx_abort;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid, r_rx_perr, r_rx_ferr;

    logic          w_clk, w_dat, w_mid, w_end, w_chg;
    logic          w_tx_done, w_tx_abort, w_tx_bit;
    logic          w_pend, w_ready;
    logic [7:0]    w_head;

    assign w_clk = r_clk_s2;
    assign w_dat = r_dat_s2;
    assign w_mid = (r_tmr == MID_TC);
    assign w_end = (r_tmr == HALF_TC);
    assign w_chg = (w_nxt != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_DEV_TXFIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;
    logic       w_full, w_push;

    assign w_full  = r_cnt[2];
    assign w_ready = !w_full || w_tx_done;
    assign w_push  = bus.tx_valid && w_ready;
    assign w_pend  = (r_cnt != 3'd0);
    assign w_head  = r_fifo[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= bus.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push)    r_wp <= r_wp + 2'd1;
            if (w_tx_done) r_rp <= r_rp + 2'd1;
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_tx_done};
        end
    end
`else
    logic       r_pend;
    logic [7:0] r_pend_data;

    assign w_ready = !r_pend;
    assign w_pend  = r_pend;
    assign w_head  = r_pend_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_data <= 8'h00;
        end else if (w_tx_done) begin
            r_pend <= 1'b0;
        end else if (bus.tx_valid && !r_pend) begin
            r_pend      <= 1'b1;
            r_pend_data <= bus.tx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_tx_done  = 1'b0;
        w_tx_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clk && !w_dat)               w_nxt = S_RX_WAIT;
                else if (w_pend && r_tmr == IDLE_TC) w_nxt = S_TX_HI;
            end
            S_TX_HI: begin
                if (w_mid && !w_clk) begin
                    w_nxt      = S_WAIT_REL;
                    w_tx_abort = 1'b1;
                end else if (w_end) begin
                    w_nxt = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (w_end) begin
                    if (r_bitcnt == 4'd10) begin
                        w_nxt     = S_IDLE;
                        w_tx_done = 1'b1;
                    end else begin
                        w_nxt = S_TX_HI;
                    end
                end
            end
            S_WAIT_REL:  if (w_clk) w_nxt = S_IDLE;
            S_RX_WAIT:   if (w_end) w_nxt = S_RX_LO;
            S_RX_LO:     if (w_end) w_nxt = S_RX_HI;
            S_RX_HI: begin
                if (w_mid && !w_clk) w_nxt = S_WAIT_REL;
                else if (w_end)      w_nxt = (r_bitcnt == 4'd9) ? S_RX_ACK_LO : S_RX_LO;
            end
            S_RX_ACK_LO: if (w_end) w_nxt = S_RX_ACK_HI;
            S_RX_ACK_HI: if (w_end) w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_bit = 1'b1;
        if (r_bitcnt == 4'd0)      w_tx_bit = 1'b0;
        else if (r_bitcnt <= 4'd8) w_tx_bit = r_shift[0];
        else if (r_bitcnt == 4'd9) w_tx_bit = r_par;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr      <= '0;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b1;
            r_stop     <= 1'b0;
            r_clk_od   <= 1'b1;
            r_dat_od   <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_abort <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_tx_done  <= w_tx_done;
            r_tx_abort <= w_tx_abort;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_clk_od   <= !(w_nxt == S_TX_LO || w_nxt == S_RX_LO || w_nxt == S_RX_ACK_LO);

            // In IDLE the timer doubles as the bus-idle counter and saturates.
            if (w_chg)                    r_tmr <= '0;
            else if (r_state != S_IDLE)   r_tmr <= r_tmr + 1'b1;
            else if (!(w_clk && w_dat))   r_tmr <= '0;
            else if (r_tmr != IDLE_TC)    r_tmr <= r_tmr + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_bitcnt <= 4'd0;
                    r_par    <= 1'b1;
                    r_shift  <= w_head;
                    r_dat_od <= 1'b1;
                end
                S_TX_HI: begin
                    if (w_tx_abort)             r_dat_od <= 1'b1;
                    else if (r_tmr == SETUP_TC) r_dat_od <= w_tx_bit;
                end
                S_TX_LO: begin
                    if (w_end) begin
                        if (r_bitcnt == 4'd10) r_dat_od <= 1'b1;
                        if (r_bitcnt >= 4'd1 && r_bitcnt <= 4'd8) begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_par   <= r_par ^ r_shift[0];
                        end
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                S_WAIT_REL: r_dat_od <= 1'b1;
                S_RX_HI: begin
                    if (w_mid) begin
                        if (!w_clk) begin
                            r_dat_od <= 1'b1;
                        end else if (r_bitcnt <= 4'd7) begin
                            r_shift <= {w_dat, r_shift[7:1]};
                            r_par   <= r_par ^ w_dat;
                        end else if (r_bitcnt == 4'd8) begin
                            r_par <= r_par ^ w_dat;
                        end else begin
                            r_stop   <= w_dat;
                            r_dat_od <= !w_dat;
                        end
                    end else if (w_end) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                S_RX_ACK_LO: if (w_end) r_dat_od <= 1'b1;
                S_RX_ACK_HI: begin
                    if (w_end) begin
                        if (r_stop) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_rx_perr  <= r_par;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ps2_clk_od = r_clk_od;
    assign o_ps2_dat_od = r_dat_od;
    assign bus.tx_ready = w_ready;
    assign bus.tx_done  = r_tx_done;
    assign bus.tx_abort = r_tx_abort;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_perr  = r_rx_perr;
    assign bus.rx_ferr  = r_rx_ferr;
endmodule
